jt5205_feeder: RTL
==================

JT5205_FEEDER -- requirements
Module: jt5205_feeder

Interface
REQ-001 SHALL have parameter AW, default 16, ROM address width.
REQ-002 SHALL have parameter HI_FIRST, default 1: 1 plays bits [7:4] before [3:0]; 0 reverses the order.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clk  in  1  single system clock; every register is clocked on its rising edge.
REQ-005 SHALL have port start  in  1  one-cycle request to begin playback.
REQ-006 SHALL have port stop  in  1  abort playback.
REQ-007 SHALL have port start_addr  in  AW  first byte address, sampled on an accepted start.
REQ-008 SHALL have port end_addr  in  AW  last byte address (inclusive), sampled on an accepted start.
REQ-009 SHALL have port rom_addr  out  AW  byte address presented to the ROM.
REQ-010 SHALL have port rom_cs  out  1  ROM read request.
REQ-011 SHALL have port rom_ok  in  1  ROM data valid.
REQ-012 SHALL have port rom_data  in  8  ROM byte.
REQ-013 SHALL have port irq  in  1  sample strobe from the jt5205 decoder.
REQ-014 SHALL have port din  out  4  ADPCM nibble to the jt5205 decoder.
REQ-015 SHALL have port busy  out  1  playback active.
REQ-016 SHALL have port done  out  1  one-cycle pulse at normal end of playback.
REQ-017 SHALL have port underrun  out  1  one-cycle pulse when the next byte was not ready at a byte boundary.

Function
REQ-018 SHALL have states IDLE, FETCH and PLAY.
REQ-019 SHALL detect irq rising edges through a registered copy of irq; all decisions SHALL use edge = irq & ~irq_q.
REQ-020 Start in IDLE SHALL latch addr<=start_addr and end<=end_addr, set busy=1 and enter FETCH. Start outside IDLE SHALL be ignored.
REQ-021 FETCH SHALL drive rom_cs=1 and rom_addr=addr.
REQ-022 In FETCH, on rom_cs&rom_ok: cur<=rom_data, nibble select<=first, enter PLAY; rom_cs SHALL be 0 in the next cycle.
REQ-023 din SHALL be registered.
REQ-024 In PLAY, din SHALL be the selected nibble of cur, updated 1 cycle after cur or the nibble select changes.
REQ-025 In IDLE and FETCH, din SHALL hold its last value; in IDLE after reset or stop, din SHALL be 0.
REQ-026 Prefetch: in PLAY, while no prefetched byte is valid and addr!=end, SHALL drive rom_cs=1 with rom_addr=addr+1 (mod 2^AW); on rom_ok SHALL store nxt<=rom_data, set nxt_vld=1 and drop rom_cs.
REQ-027 In PLAY, an edge while the first nibble is selected SHALL select the second nibble.
REQ-028 Edge on the second nibble with addr==end: SHALL pulse done=1, clear busy and enter IDLE.
REQ-029 Edge on the second nibble with nxt_vld=1: SHALL load cur<=nxt, addr<=addr+1, nxt_vld<=0 and select the first nibble.
REQ-030 Edge on the second nibble with nxt_vld=0 and addr!=end: SHALL cancel any pending prefetch, pulse underrun, set addr<=addr+1 and enter FETCH.
REQ-031 rom_data SHALL be ignored unless rom_cs&rom_ok in the same cycle.
REQ-032 Address arithmetic SHALL wrap modulo 2^AW; end<start SHALL play through the wrap. Byte count is ((end-start) mod 2^AW)+1; start==end plays exactly 2 nibbles.
REQ-033 irq edges in IDLE or FETCH SHALL be ignored and SHALL NOT be queued.
REQ-034 stop in any state SHALL force IDLE on the next cycle: rom_cs=0, busy=0, nxt_vld=0, din=0, no done pulse.
REQ-035 stop asserted together with start SHALL win.
REQ-036 done and underrun SHALL never be high for more than one cycle and SHALL never be high in the same cycle.

Reset
REQ-037 While rst=1: state=IDLE; rom_cs, busy, done, underrun, din, rom_addr, nxt_vld and irq_q SHALL all be 0.
REQ-038 Reset asserted mid-playback SHALL abandon the transfer immediately with no done pulse.
REQ-039 After reset release, the block SHALL accept a start on the first clock edge.

Verification
REQ-040 start_addr=0x0010, end_addr=0x0011, ROM[0x10]=0xA5, ROM[0x11]=0x3C, rom_ok 2 cycles after rom_cs, HI_FIRST=1 -> din sequence A,5,3,C on successive irq edges; done pulses once, on the 4th edge.
REQ-041 Same stimulus with HI_FIRST=0 -> din sequence 5,A,C,3.
REQ-042 start_addr=0xFFFF, end_addr=0x0000 -> ROM reads at 0xFFFF then 0x0000, 4 nibbles, then done.
REQ-043 rom_ok delayed past the second irq edge of byte 0 -> underrun pulse, FETCH at addr+1, playback resumes with the correct nibbles and ends with done.
REQ-044 stop during PLAY with a pending prefetch -> next cycle rom_cs=0, busy=0, din=0, no done; a following start replays from start_addr.
REQ-045 start while busy plus irq edges while in FETCH -> both ignored; nibble order unchanged versus the undisturbed run.

Source files
------------

// File: rtl/jt5205_feeder.sv
// ROM-to-jt5205 nibble streamer: fetches ADPCM bytes from ROM and hands one nibble to the
// decoder per irq strobe, prefetching the next byte while the current one is playing.
module jt5205_feeder #(
    parameter int AW       = 16,
    parameter int HI_FIRST = 1
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [7:0]    rom_data,
    input  logic          irq,
    output logic [3:0]    din,
    output logic          busy,
    output logic          done,
    output logic          underrun
);
    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t        state, state_d;
    logic [AW-1:0] addr, addr_d, last_addr, last_addr_d, rom_addr_d, addr_inc;
    logic [7:0]    cur, cur_d, nxt, nxt_d;
    logic          nxt_vld, nxt_vld_d, second, second_d;
    logic          irq_q, irq_edge;
    logic          rom_cs_d, busy_d, done_d, underrun_d;
    logic [3:0]    din_d, nib_first, nib_second;

    assign irq_edge   = irq & ~irq_q;
    assign addr_inc   = addr + AW'(1);
    assign nib_first  = (HI_FIRST != 0) ? cur[7:4] : cur[3:0];
    assign nib_second = (HI_FIRST != 0) ? cur[3:0] : cur[7:4];

    always_comb begin
        state_d     = state;
        addr_d      = addr;
        last_addr_d = last_addr;
        cur_d       = cur;
        nxt_d       = nxt;
        nxt_vld_d   = nxt_vld;
        second_d    = second;
        din_d       = din;
        busy_d      = busy;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        rom_cs_d    = rom_cs;
        rom_addr_d  = rom_addr;
        if (stop) begin
            state_d   = IDLE;
            rom_cs_d  = 1'b0;
            busy_d    = 1'b0;
            nxt_vld_d = 1'b0;
            second_d  = 1'b0;
            din_d     = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_d      = start_addr;
                        last_addr_d = end_addr;
                        busy_d      = 1'b1;
                        rom_cs_d    = 1'b1;
                        rom_addr_d  = start_addr;
                        state_d     = FETCH;
                    end
                end
                FETCH: begin
                    if (rom_cs && rom_ok) begin
                        cur_d    = rom_data;
                        second_d = 1'b0;
                        rom_cs_d = 1'b0;
                        state_d  = PLAY;
                    end
                end
                PLAY: begin
                    din_d = second ? nib_second : nib_first;
                    // Prefetch of the following byte; re-armed one cycle after each byte load.
                    if (rom_cs && rom_ok) begin
                        nxt_d     = rom_data;
                        nxt_vld_d = 1'b1;
                        rom_cs_d  = 1'b0;
                    end else if (!rom_cs && !nxt_vld && addr != last_addr) begin
                        rom_cs_d   = 1'b1;
                        rom_addr_d = addr_inc;
                    end
                    if (irq_edge) begin
                        if (!second) begin
                            second_d = 1'b1;
                        end else if (addr == last_addr) begin
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            rom_cs_d = 1'b0;
                            state_d  = IDLE;
                        end else if (nxt_vld) begin
                            cur_d     = nxt;
                            addr_d    = addr_inc;
                            nxt_vld_d = 1'b0;
                            second_d  = 1'b0;
                        end else begin
                            // Byte not ready in time: restart as a plain fetch of the next byte.
                            underrun_d = 1'b1;
                            addr_d     = addr_inc;
                            nxt_vld_d  = 1'b0;
                            rom_cs_d   = 1'b1;
                            rom_addr_d = addr_inc;
                            state_d    = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            last_addr <= '0;
            cur       <= 8'd0;
            nxt       <= 8'd0;
            nxt_vld   <= 1'b0;
            second    <= 1'b0;
            irq_q     <= 1'b0;
            din       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
        end else begin
            state     <= state_d;
            addr      <= addr_d;
            last_addr <= last_addr_d;
            cur       <= cur_d;
            nxt       <= nxt_d;
            nxt_vld   <= nxt_vld_d;
            second    <= second_d;
            irq_q     <= irq;
            din       <= din_d;
            busy      <= busy_d;
            done      <= done_d;
            underrun  <= underrun_d;
            rom_cs    <= rom_cs_d;
            rom_addr  <= rom_addr_d;
        end
    end
endmodule
